// File: rtl/rr_stream_mux_pkg.sv
// ----------------------------------------------------------------------------
// rr_stream_mux_pkg
// Shared definitions for the round-robin packet multiplexer:
//   - state_e     : FSM encoding (IDLE = 1'b0, LOCKED = 1'b1)
//   - clog2()     : index-width helper used for the channel index
//   - NUM_CH_DEF  : default number of input channels
//   - DATA_W_DEF  : default data width per channel
// ----------------------------------------------------------------------------
package rr_stream_mux_pkg;

    localparam int NUM_CH_DEF = 4;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    // Smallest width able to index 'value' distinct items (minimum 1 bit).
    function automatic int clog2(input int value);
        int result;
        result = 1;
        while ((32'sd1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_stream_mux_if.sv
// ----------------------------------------------------------------------------
// rr_stream_mux_if
// Bundles the N input streams and the single output stream of rr_stream_mux.
//   data_i  [NUM_CH*DATA_W] channel k data at [k*DATA_W +: DATA_W]
//   valid_i [NUM_CH]        per-channel beat valid
//   last_i  [NUM_CH]        per-channel end-of-packet, qualified by valid_i
//   ready_o [NUM_CH]        per-channel accept
//   data_o  [DATA_W]        output data
//   valid_o                 output valid
//   last_o                  output end-of-packet
//   ch_o    [SEL_W]         source channel of the current output beat
//   ready_i                 downstream accept
// Modports: master = producers/consumer side, slave = the multiplexer.
// ----------------------------------------------------------------------------
interface rr_stream_mux_if
    import rr_stream_mux_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();
    localparam int SEL_W = clog2(NUM_CH);

    logic [NUM_CH*DATA_W-1:0] data_i;
    logic [NUM_CH-1:0]        valid_i;
    logic [NUM_CH-1:0]        last_i;
    logic [NUM_CH-1:0]        ready_o;
    logic [DATA_W-1:0]        data_o;
    logic                     valid_o;
    logic                     last_o;
    logic [SEL_W-1:0]         ch_o;
    logic                     ready_i;

    modport master (
        output data_i, valid_i, last_i, ready_i,
        input  ready_o, data_o, valid_o, last_o, ch_o
    );

    modport slave (
        input  data_i, valid_i, last_i, ready_i,
        output ready_o, data_o, valid_o, last_o, ch_o
    );
endinterface

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational rotating-priority encoder. The search starts at the
// channel after ptr and wraps, so the channel named by ptr is served last.
//   req     [NUM_CH] request vector
//   ptr     [SEL_W]  last served channel
//   gnt_idx [SEL_W]  first requester after ptr (0 when none)
//   gnt_vld          at least one request present
// ----------------------------------------------------------------------------
module rr_arbiter
    import rr_stream_mux_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF
) (
    input  logic [NUM_CH-1:0]          req,
    input  logic [clog2(NUM_CH)-1:0]   ptr,
    output logic [clog2(NUM_CH)-1:0]   gnt_idx,
    output logic                       gnt_vld
);
    localparam int SEL_W = clog2(NUM_CH);

    // Walk ptr+1 .. ptr+NUM_CH (mod NUM_CH); the first hit wins.
    always_comb begin
        int cand;
        cand    = 0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = (int'(ptr) + i) % NUM_CH;
            if (!gnt_vld && req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = SEL_W'(cand);
            end else begin
                gnt_vld = gnt_vld;
            end
        end
    end
endmodule

// File: rtl/rr_stream_mux.sv
// ----------------------------------------------------------------------------
// rr_stream_mux
// N-channel packet multiplexer with round-robin arbitration. A channel keeps
// the grant until its last beat is accepted; the output stream is registered
// and tagged with the source channel index.
//   clk_i  clock, rising edge
//   rst_i  synchronous active-high reset
//   bus    rr_stream_mux_if slave modport (input streams + output stream)
// The only combinational path through the block is bus.ready_i -> bus.ready_o.
// ----------------------------------------------------------------------------
module rr_stream_mux
    import rr_stream_mux_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic           clk_i,
    input  logic           rst_i,
    rr_stream_mux_if.slave bus
);
    localparam int SEL_W = clog2(NUM_CH);

    state_e             state_r;
    state_e             state_next_s;
    logic [SEL_W-1:0]   ptr_r;
    logic [SEL_W-1:0]   gnt_r;
    logic [SEL_W-1:0]   arb_idx_s;
    logic               arb_vld_s;

    logic [DATA_W-1:0]  gnt_data_s;
    logic               gnt_valid_s;
    logic               gnt_last_s;
    logic               out_ready_s;
    logic               accept_s;
    logic [NUM_CH-1:0]  ready_s;

    logic [DATA_W-1:0]  data_r;
    logic               valid_r;
    logic               last_r;
    logic [SEL_W-1:0]   ch_r;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req     (bus.valid_i),
        .ptr     (ptr_r),
        .gnt_idx (arb_idx_s),
        .gnt_vld (arb_vld_s)
    );

    // Select the granted channel's data, valid and last.
    always_comb begin
        gnt_data_s  = '0;
        gnt_valid_s = 1'b0;
        gnt_last_s  = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (gnt_r == SEL_W'(k)) begin
                gnt_data_s  = bus.data_i[k*DATA_W +: DATA_W];
                gnt_valid_s = bus.valid_i[k];
                gnt_last_s  = bus.last_i[k];
            end else begin
                gnt_data_s  = gnt_data_s;
            end
        end
    end

    // The output register can take a beat when it is empty or being drained.
    assign out_ready_s = !valid_r || bus.ready_i;
    assign accept_s    = (state_r == ST_LOCKED) && gnt_valid_s && out_ready_s;

    // FSM state register plus grant/pointer bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            ptr_r   <= SEL_W'(NUM_CH - 1);
            gnt_r   <= '0;
        end else begin
            state_r <= state_next_s;
            if ((state_r == ST_IDLE) && arb_vld_s) begin
                gnt_r <= arb_idx_s;
            end else begin
                gnt_r <= gnt_r;
            end
            // The channel just served drops to lowest priority.
            if (accept_s && gnt_last_s) begin
                ptr_r <= gnt_r;
            end else begin
                ptr_r <= ptr_r;
            end
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (arb_vld_s) begin
                    state_next_s = ST_LOCKED;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (accept_s && gnt_last_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_LOCKED;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs: only the granted channel sees ready, and only while LOCKED.
    always_comb begin
        ready_s = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            ready_s[k] = (state_r == ST_LOCKED) && (gnt_r == SEL_W'(k)) && out_ready_s;
        end
    end

    // Output stage: load on accept, clear when drained, hold while stalled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_r  <= '0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            ch_r    <= '0;
        end else if (accept_s) begin
            data_r  <= gnt_data_s;
            valid_r <= 1'b1;
            last_r  <= gnt_last_s;
            ch_r    <= gnt_r;
        end else if (bus.ready_i) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign bus.ready_o = ready_s;
    assign bus.data_o  = data_r;
    assign bus.valid_o = valid_r;
    assign bus.last_o  = last_r;
    assign bus.ch_o    = ch_r;
endmodule
